button_press_decoder: RTL and testbench
=======================================

BUTTON_PRESS_DECODER -- requirements
Module: button_press_decoder

Interface
- REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles needed to accept a level change (20 ms at 50 MHz).
- REQ-002 SHALL have parameter LONG_CYCLES, default 25000000: debounced-hold cycles that qualify as a long press.
- REQ-003 SHALL have parameter REPEAT_CYCLES, default 10000000: auto-repeat period while a long press is held.
- REQ-004 SHALL have parameter ACTIVE_LOW, default 1: 1 means a raw input of 0 is "pressed".
- REQ-005 SHALL have input clk, 1 bit: 50 MHz system clock.
- REQ-006 SHALL have input reset, 1 bit: reset, asynchronous, active-high.
- REQ-007 SHALL have input btn_raw, 2 bits: asynchronous mechanical buttons; bit0 = increment, bit1 = decrement.
- REQ-008 SHALL have output btn_level, 2 bits: debounced pressed state, 1 = pressed.
- REQ-009 SHALL have output short_pulse, 2 bits: one-cycle pulse on release of a short press.
- REQ-010 SHALL have output long_pulse, 2 bits: one-cycle pulse when the hold reaches LONG_CYCLES.
- REQ-011 SHALL have output repeat_pulse, 2 bits: one-cycle pulse every REPEAT_CYCLES while a long press is held.

Function
- REQ-012 SHALL process the two channels independently and identically; no cross-channel interaction.
- REQ-013 SHALL pass each raw bit through a 2-flop synchronizer, then invert it when ACTIVE_LOW=1.
- REQ-014 SHALL debounce per channel:
  - The counter increments while the synchronized value differs from btn_level.
  - The counter clears whenever the two values are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while they still differ, btn_level toggles and the counter clears.
- REQ-015 SHALL size all counters at 26 bits minimum; no counter wraps, and each clears at its terminal count.
- REQ-016 SHALL implement a per-channel FSM with states IDLE, HELD and LONG, reset to IDLE.
- REQ-017 IDLE -> HELD on a btn_level rising edge, with the hold counter cleared to 0.
- REQ-018 In HELD, the hold counter increments each cycle.
  - On reaching LONG_CYCLES-1: assert long_pulse for that cycle, go to LONG, clear the repeat counter.
- REQ-019 In HELD, btn_level falling before the threshold: assert short_pulse for one cycle, go to IDLE.
- REQ-020 If the release and the threshold fall in the same cycle, the release SHALL win: short_pulse only, no long_pulse.
- REQ-021 In LONG, the repeat counter increments.
  - On reaching REPEAT_CYCLES-1: assert repeat_pulse for one cycle and clear the counter.
- REQ-022 In LONG, btn_level falling SHALL return the FSM to IDLE with no pulse; a pending repeat in that cycle is suppressed.
- REQ-023 At most one of short_pulse, long_pulse and repeat_pulse per channel SHALL be high in any cycle.
- REQ-024 All pulse outputs SHALL be registered and exactly one clk cycle wide.
- REQ-025 Latency from a raw edge to the btn_level change SHALL be 2 + DEBOUNCE_CYCLES cycles for a clean edge.
- REQ-026 short_pulse SHALL assert in the cycle after btn_level falls.
- REQ-027 long_pulse SHALL assert LONG_CYCLES cycles after btn_level rises.
- REQ-028 Glitches shorter than DEBOUNCE_CYCLES SHALL produce no output activity.
- REQ-029 Both buttons held together SHALL each produce their own pulse stream; the downstream timekeeper resolves any conflict.

Reset
- REQ-030 While reset is high, all outputs SHALL be 0, all counters 0, FSMs in IDLE, and synchronizer flops at the "released" level.
- REQ-031 Reset asserted mid-press SHALL discard the press and emit no pulse.
  - After reset deasserts with the button still held, the channel SHALL first debounce to pressed, then start a fresh HELD sequence.
- REQ-032 Outputs SHALL respond to reset asynchronously; deassertion is synchronous to clk.

Verification (bench parameters: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, ACTIVE_LOW=1)
- REQ-033 Bounce rejection: btn_raw[0] low for 3 cycles, then high -> btn_level, short_pulse and long_pulse stay 0.
- REQ-034 Short press: btn_raw[0] low for 12 cycles, then high.
  - btn_level[0] rises 6 cycles after the falling raw edge.
  - Exactly one short_pulse[0], one cycle after btn_level[0] falls.
  - No long_pulse.
- REQ-035 Long press with repeat: btn_raw[1] low for 60 cycles.
  - long_pulse[1] fires 20 cycles after btn_level[1] rises.
  - repeat_pulse[1] then fires every 8 cycles.
  - No short_pulse on release.
- REQ-036 Threshold/release race: release timed so btn_level falls in the cycle the hold count reaches 19 -> short_pulse only.
- REQ-037 Reset mid-hold: assert reset 10 cycles into HELD -> all outputs 0 immediately and no pulse on release.
  - If the button is still held after deassertion, long_pulse arrives 2+4+20 cycles later.
- REQ-038 Simultaneous buttons: both low for 30 cycles -> long_pulse on both bits in the same cycle and no cross-talk.

Source files
------------

// File: rtl/button_press_decoder.sv
// Two-channel push-button front end. Each raw contact is synchronised,
// polarity-corrected and debounced, then a small per-channel FSM classifies
// the press as short (pulse on release), long (pulse once the hold threshold
// is reached) and auto-repeat (periodic pulse while a long press is held).
// Both channels are identical and fully independent.
//
// Handshake: there is no valid/ready pair here. Every pulse output is a
// registered, single-cycle strobe and consumers must sample it on every clk.
//
// The hold and repeat thresholds are assumed to be at least 2 cycles.
module button_press_decoder #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn_raw,
    output logic [1:0] btn_level,
    output logic [1:0] short_pulse,
    output logic [1:0] long_pulse,
    output logic [1:0] repeat_pulse,
    output logic [3:0] fsm_state_o
);

    // Counters are wide enough for the 50 MHz defaults with plenty of margin.
    localparam int CNT_W = 32;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    // Raw level that means "not pressed"; the synchronisers reset to it.
    localparam logic RELEASED_RAW = (ACTIVE_LOW != 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HELD = 2'd1;
    localparam logic [1:0] ST_LONG = 2'd2;

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic             sync1_q;
        logic             sync2_q;
        logic             pressed;
        logic             level_q;
        logic             level_d;
        logic [CNT_W-1:0] deb_cnt_q;
        logic [CNT_W-1:0] deb_cnt_d;
        logic [1:0]       state_q;
        logic [1:0]       state_d;
        logic [CNT_W-1:0] hold_cnt_q;
        logic [CNT_W-1:0] hold_cnt_d;
        logic [CNT_W-1:0] hold_next;
        logic [CNT_W-1:0] rep_cnt_q;
        logic [CNT_W-1:0] rep_cnt_d;
        logic             short_q;
        logic             short_d;
        logic             long_q;
        logic             long_d;
        logic             rep_q;
        logic             rep_d;

        // Two-flop synchroniser for the asynchronous contact.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync1_q <= RELEASED_RAW;
                sync2_q <= RELEASED_RAW;
            end else begin
                sync1_q <= btn_raw[c];
                sync2_q <= sync1_q;
            end
        end

        // 1 = pressed, independent of the contact polarity.
        assign pressed = sync2_q ^ RELEASED_RAW;

        // Debounce: count consecutive cycles of disagreement, flip on the last one.
        always_comb begin
            level_d   = level_q;
            deb_cnt_d = '0;
            if (pressed != level_q) begin
                if (deb_cnt_q == DEB_LAST) begin
                    level_d   = ~level_q;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_W'(1);
                end
            end
        end

        // Press classifier. HELD compares the incremented hold count because
        // the IDLE->HELD step already consumes the first cycle after the rise,
        // which puts the long pulse exactly LONG_CYCLES after btn_level rises.
        // A release always takes priority over a threshold in the same cycle.
        always_comb begin
            state_d    = state_q;
            hold_cnt_d = hold_cnt_q;
            rep_cnt_d  = rep_cnt_q;
            hold_next  = hold_cnt_q + CNT_W'(1);
            short_d    = 1'b0;
            long_d     = 1'b0;
            rep_d      = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (level_q) begin
                        state_d    = ST_HELD;
                        hold_cnt_d = '0;
                    end
                end
                ST_HELD: begin
                    if (!level_q) begin
                        short_d    = 1'b1;
                        state_d    = ST_IDLE;
                        hold_cnt_d = '0;
                    end else if (hold_next == LONG_LAST) begin
                        long_d     = 1'b1;
                        state_d    = ST_LONG;
                        hold_cnt_d = '0;
                        rep_cnt_d  = '0;
                    end else begin
                        hold_cnt_d = hold_next;
                    end
                end
                ST_LONG: begin
                    if (!level_q) begin
                        state_d   = ST_IDLE;
                        rep_cnt_d = '0;
                    end else if (rep_cnt_q == REP_LAST) begin
                        rep_d     = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                    rep_cnt_d  = '0;
                end
            endcase
        end

        // State, counters and registered pulse outputs.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                level_q    <= 1'b0;
                deb_cnt_q  <= '0;
                state_q    <= ST_IDLE;
                hold_cnt_q <= '0;
                rep_cnt_q  <= '0;
                short_q    <= 1'b0;
                long_q     <= 1'b0;
                rep_q      <= 1'b0;
            end else begin
                level_q    <= level_d;
                deb_cnt_q  <= deb_cnt_d;
                state_q    <= state_d;
                hold_cnt_q <= hold_cnt_d;
                rep_cnt_q  <= rep_cnt_d;
                short_q    <= short_d;
                long_q     <= long_d;
                rep_q      <= rep_d;
            end
        end

        assign btn_level[c]         = level_q;
        assign short_pulse[c]       = short_q;
        assign long_pulse[c]        = long_q;
        assign repeat_pulse[c]      = rep_q;
        assign fsm_state_o[2*c +: 2] = state_q;
    end

endmodule

// File: tb/tb_button_press_decoder.sv
// Bench for button_press_decoder (DEBOUNCE=4, LONG=20, REPEAT=8, active low).
// The reference model works on the recorded press samples: a level change is
// accepted once the last DEBOUNCE synchronised samples all disagree with the
// current level, and pulses follow from the rise/fall times by arithmetic.
module tb_button_press_decoder;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 8;
    localparam int MAXC = 8192;

    localparam logic [1:0] K_LEVEL = 2'd0;
    localparam logic [1:0] K_SHORT = 2'd1;
    localparam logic [1:0] K_LONG  = 2'd2;
    localparam logic [1:0] K_REP   = 2'd3;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] btn_raw;
    logic [1:0] btn_level;
    logic [1:0] short_pulse;
    logic [1:0] long_pulse;
    logic [1:0] repeat_pulse;
    logic [3:0] fsm_state;

    always #5 clk = ~clk;

    button_press_decoder #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG),
        .REPEAT_CYCLES  (REP),
        .ACTIVE_LOW     (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse),
        .repeat_pulse(repeat_pulse),
        .fsm_state_o (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [18:0] exp_q[$];          // {channel, kind, cycle}

    logic smp [0:1][0:MAXC-1];      // pressed sample in effect after each edge
    logic m_level [0:1];
    int   m_rise [0:1];
    int   m_fell [0:1];

    int   obs_cnt [0:1][0:3];
    int   obs_last [0:1][0:3];
    int   obs_rise_cyc [0:1];
    int   obs_fall_cyc [0:1];
    int   base [0:1][0:3];
    int   both_long = 0;
    logic [1:0] prev_lvl;
    logic [3:0] exp_v [0:1];
    logic [3:0] act_v [0:1];

    // ---------------- reference model ----------------
    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            m_level[c] = 1'b0;
            m_rise[c]  = -1000;
            m_fell[c]  = -1000;
        end
    endtask

    function automatic void push_exp(input int c, input logic [1:0] k, input int t);
        exp_q.push_back({1'(c), k, 16'(t)});
    endfunction

    function automatic bit window_flips(input int c, input int t);
        for (int k = 0; k < DEB; k++) begin
            int   idx;
            logic s;
            idx = t - 3 - k;
            s   = (idx < 0) ? 1'b0 : smp[c][idx];
            if (s == m_level[c]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge(input int t);
        for (int c = 0; c < 2; c++) begin
            if (m_level[c]) begin
                if (t - m_rise[c] == LONG)
                    push_exp(c, K_LONG, t);
                else if (t - m_rise[c] > LONG && (t - m_rise[c] - LONG) % REP == 0)
                    push_exp(c, K_REP, t);
            end else if (m_fell[c] == t - 1 && (m_fell[c] - m_rise[c]) < LONG) begin
                push_exp(c, K_SHORT, t);
            end
            if (window_flips(c, t)) begin
                m_level[c] = ~m_level[c];
                push_exp(c, K_LEVEL, t);
                if (m_level[c]) m_rise[c] = t;
                else            m_fell[c] = t;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input logic [1:0] raw, input logic rst);
        @(posedge clk);
        cyc++;
        if (!reset) model_edge(cyc);
        #1;
        if (rst && !reset) begin
            exp_q.delete();
            model_clear();
        end
        reset   = rst;
        btn_raw = raw;
        for (int c = 0; c < 2; c++) smp[c][cyc] = rst ? 1'b0 : ~raw[c];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(2'b11, 1'b0);
    endtask

    task automatic press(input logic [1:0] mask, input int n, output int start);
        start = 0;
        for (int i = 0; i < n; i++) begin
            tick(~mask, 1'b0);
            if (i == 0) start = cyc;
        end
        tick(2'b11, 1'b0);
    endtask

    task automatic snap();
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < 4; k++) base[c][k] = obs_cnt[c][k];
    endtask

    function automatic int delta(input int c, input int k);
        return obs_cnt[c][k] - base[c][k];
    endfunction

    task automatic check_eq(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            n_vec++;
            if ({btn_level, short_pulse, long_pulse, repeat_pulse, fsm_state} != 12'h000) begin
                n_err++;
                $display("FAIL reset_outputs @%0d: got lvl=%b s=%b l=%b r=%b st=%h, expected all 0",
                         cyc, btn_level, short_pulse, long_pulse, repeat_pulse, fsm_state);
            end
            prev_lvl = 2'b00;
        end else begin
            exp_v[0] = 4'b0;
            exp_v[1] = 4'b0;
            while (exp_q.size() > 0) begin
                logic [18:0] e;
                e = exp_q[0];
                if (int'(e[15:0]) > cyc) break;
                void'(exp_q.pop_front());
                exp_v[e[18]][e[17:16]] = 1'b1;
            end
            for (int c = 0; c < 2; c++) begin
                act_v[c] = {repeat_pulse[c], long_pulse[c], short_pulse[c],
                            btn_level[c] ^ prev_lvl[c]};
                if (exp_v[c] != 4'b0 || act_v[c] != 4'b0) begin
                    n_vec++;
                    if (act_v[c] != exp_v[c]) begin
                        n_err++;
                        $display("FAIL ch%0d_events @%0d: got rep/long/short/lvl=%b, expected %b",
                                 c, cyc, act_v[c], exp_v[c]);
                    end
                end
                for (int k = 0; k < 4; k++) begin
                    if (act_v[c][k]) begin
                        obs_cnt[c][k]++;
                        obs_last[c][k] = cyc;
                    end
                end
                if (act_v[c][0]) begin
                    if (btn_level[c]) obs_rise_cyc[c] = cyc;
                    else              obs_fall_cyc[c] = cyc;
                end
            end
            if (long_pulse == 2'b11) both_long++;
            prev_lvl = btn_level;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int         s;
        int         d;
        int         run [0:1];
        logic [1:0] cur;

        reset   = 1'b1;
        btn_raw = 2'b11;
        prev_lvl = 2'b00;
        smp[0][0] = 1'b0;
        smp[1][0] = 1'b0;
        model_clear();

        repeat (4) tick(2'b11, 1'b1);
        idle(10);

        // Bounce shorter than the debounce window.
        snap();
        for (int i = 0; i < 3; i++) tick(2'b10, 1'b0);
        idle(20);
        check_eq("bounce_level", delta(0, K_LEVEL), 0);
        check_eq("bounce_short", delta(0, K_SHORT), 0);
        check_eq("bounce_long",  delta(0, K_LONG), 0);

        // Short press, 12 cycles.
        snap();
        press(2'b01, 12, s);
        idle(30);
        check_eq("short_rise_latency", obs_rise_cyc[0] - s, 6);
        check_eq("short_count", delta(0, K_SHORT), 1);
        check_eq("short_after_fall", obs_last[0][K_SHORT] - obs_fall_cyc[0], 1);
        check_eq("short_no_long", delta(0, K_LONG), 0);

        // Long press with repeat on channel 1, 60 cycles.
        snap();
        press(2'b10, 60, s);
        idle(30);
        check_eq("long_count", delta(1, K_LONG), 1);
        check_eq("long_after_rise", obs_last[1][K_LONG] - obs_rise_cyc[1], 20);
        check_eq("repeat_count", delta(1, K_REP), 5);
        check_eq("repeat_last_offset", obs_last[1][K_REP] - obs_last[1][K_LONG], 40);
        check_eq("long_no_short", delta(1, K_SHORT), 0);
        check_eq("long_no_crosstalk", delta(0, K_LEVEL), 0);

        // Release lands in the threshold cycle: release wins.
        snap();
        press(2'b01, 19, s);
        idle(30);
        check_eq("race_short", delta(0, K_SHORT), 1);
        check_eq("race_long", delta(0, K_LONG), 0);

        // One cycle longer: the long press wins.
        snap();
        press(2'b01, 20, s);
        idle(30);
        check_eq("edge_long", delta(0, K_LONG), 1);
        check_eq("edge_short", delta(0, K_SHORT), 0);
        check_eq("edge_repeat", delta(0, K_REP), 0);

        // Reset ten cycles into HELD, button kept held afterwards.
        snap();
        for (int i = 0; i < 17; i++) tick(2'b10, 1'b0);
        for (int i = 0; i < 3; i++) tick(2'b10, 1'b1);
        tick(2'b10, 1'b0);
        d = cyc;
        for (int i = 0; i < 39; i++) tick(2'b10, 1'b0);
        tick(2'b11, 1'b0);
        idle(30);
        check_eq("rst_long_count", delta(0, K_LONG), 1);
        check_eq("rst_long_latency", obs_last[0][K_LONG] - d, 26);
        check_eq("rst_no_short", delta(0, K_SHORT), 0);

        // Both buttons together.
        snap();
        s = both_long;
        press(2'b11, 30, d);
        idle(30);
        check_eq("both_same_cycle", both_long - s, 1);
        check_eq("both_long0", delta(0, K_LONG), 1);
        check_eq("both_long1", delta(1, K_LONG), 1);
        check_eq("both_short0", delta(0, K_SHORT), 0);

        // Randomised independent press/glitch traffic with occasional resets.
        cur    = 2'b11;
        run[0] = 0;
        run[1] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (run[c] == 0) begin
                    cur[c] = ~cur[c];
                    run[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5))
                                                         : int'($urandom_range(6, 45));
                end
                run[c]--;
            end
            if (i == 1200 || i == 2300) begin
                for (int r = 0; r < 3; r++) tick(cur, 1'b1);
            end
            tick(cur, 1'b0);
        end
        idle(40);

        @(negedge clk);
        #1;
        check_eq("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
